// File: rtl/ohs_comm_pkg.sv
// ohs_comm_pkg: shared frame constants and framer state encoding
package ohs_comm_pkg;
  localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;
  localparam int FRAME_LEN = 7;
  localparam int IDX_W = 2;
  typedef enum logic [2:0] {IDLE, HDR, ADR, DAT, CHK} state_e;
endpackage

// File: rtl/ohs_comm_tx_framer_if.sv
// ohs_comm_tx_framer_if: word valid/ready input and byte stream output; slave = framer side, master = environment side
interface ohs_comm_tx_framer_if #(parameter int ADDR_WIDTH = 2);
  logic s_word_valid;
  logic s_word_ready;
  logic [ADDR_WIDTH-1:0] s_word_addr;
  logic [31:0] s_word_data;
  logic [7:0] m_byte_tdata;
  logic m_byte_tvalid;
  logic m_byte_tready;
  modport slave (
    input  s_word_valid, s_word_addr, s_word_data, m_byte_tready,
    output s_word_ready, m_byte_tdata, m_byte_tvalid
  );
  modport master (
    output s_word_valid, s_word_addr, s_word_data, m_byte_tready,
    input  s_word_ready, m_byte_tdata, m_byte_tvalid
  );
endinterface

// File: rtl/ohs_comm_tx_framer.sv
// ohs_comm_tx_framer: takes {addr,data} words on bus.s_word_*, emits HDR/addr/data[4]/xor frames on bus.m_byte_*, reports busy and a wrapping frame_count
module ohs_comm_tx_framer
  import ohs_comm_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEF
) (
  input  logic s_axi_aclk,
  input  logic s_axi_aresetn,
  ohs_comm_tx_framer_if.slave bus,
  output logic busy,
  output logic [15:0] frame_count
);
  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0] addr_q, addr_d, chk_q, chk_d, tdata_q, tdata_d;
  logic [31:0] data_q, data_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic en_q, en_d;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic ready, fire, accept;
  assign addr_in = bus.s_word_addr;
  // en_q keeps ready low while reset is held and releases it on the first clock after
  assign ready = en_q && (state_q == IDLE || (state_q == CHK && bus.m_byte_tready));
  assign accept = bus.s_word_valid && ready;
  assign fire = bus.m_byte_tvalid && bus.m_byte_tready;
  assign bus.s_word_ready = ready;
  assign bus.m_byte_tvalid = state_q != IDLE;
  assign bus.m_byte_tdata = tdata_q;
  assign busy = state_q != IDLE;
  assign frame_count = frame_count_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    addr_d = accept ? 8'(addr_in) : addr_q;
    data_d = accept ? bus.s_word_data : data_q;
    chk_d = accept ? addr_d ^ data_d[7:0] ^ data_d[15:8] ^ data_d[23:16] ^ data_d[31:24] : chk_q;
    tdata_d = tdata_q;
    frame_count_d = frame_count_q;
    en_d = 1'b1;
    case (state_q)
      IDLE: if (accept) begin
        state_d = HDR;
        tdata_d = HEADER_BYTE;
      end
      HDR: if (fire) begin
        state_d = ADR;
        tdata_d = addr_q;
      end
      ADR: if (fire) begin
        state_d = DAT;
        idx_d = '0;
        tdata_d = data_q[7:0];
      end
      DAT: if (fire) begin
        idx_d = idx_q + 2'd1;
        state_d = idx_q == 2'd3 ? CHK : DAT;
        tdata_d = idx_q == 2'd3 ? chk_q : data_q[{idx_d, 3'b000} +: 8];
      end
      CHK: if (fire) begin
        frame_count_d = frame_count_q + 16'd1;
        state_d = accept ? HDR : IDLE;
        tdata_d = accept ? HEADER_BYTE : 8'h00;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q <= IDLE;
      idx_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      chk_q <= '0;
      tdata_q <= '0;
      frame_count_q <= '0;
      en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      addr_q <= addr_d;
      data_q <= data_d;
      chk_q <= chk_d;
      tdata_q <= tdata_d;
      frame_count_q <= frame_count_d;
      en_q <= en_d;
    end
  end
endmodule

// File: tb/tb_ohs_comm_tx_framer.sv
// tb_ohs_comm_tx_framer: scoreboard bench for the frame serialiser
module tb_ohs_comm_tx_framer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic [15:0] frame_count;
  int n_vec = 0;
  int n_err = 0;
  int pos = 0;
  int w;
  logic [7:0] exp_q[$];
  always #5 clk = ~clk;
  ohs_comm_tx_framer_if #(.ADDR_WIDTH(2)) bus ();
  ohs_comm_tx_framer #(.ADDR_WIDTH(2), .HEADER_BYTE(8'hA5)) dut (
    .s_axi_aclk(clk),
    .s_axi_aresetn(rst_n),
    .bus(bus),
    .busy(busy),
    .frame_count(frame_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void push_frame(input logic [1:0] a, input logic [31:0] d);
    logic [7:0] ab;
    ab = {6'b0, a};
    exp_q.push_back(8'hA5);
    exp_q.push_back(ab);
    for (int i = 0; i < 4; i++) exp_q.push_back(d[8*i +: 8]);
    exp_q.push_back(ab ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24]);
  endfunction
  always @(negedge clk) begin
    if (rst_n && bus.m_byte_tvalid && bus.m_byte_tready) begin
      if (exp_q.size() == 0) check("unexpected_byte_q_empty", 32'(exp_q.size()), 1);
      else begin
        check($sformatf("byte%0d", pos), {24'h0, bus.m_byte_tdata}, {24'h0, exp_q.pop_front()});
        pos = pos == 6 ? 0 : pos + 1;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [1:0] a, input logic [31:0] d, output int waited);
    bit ok;
    ok = 0;
    waited = 0;
    bus.s_word_valid = 1'b1;
    bus.s_word_addr = a;
    bus.s_word_data = d;
    push_frame(a, d);
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.s_word_ready) ok = 1;
      else waited++;
    end
    check("accept", {31'h0, ok}, 1);
    tick();
    bus.s_word_valid = 1'b0;
  endtask
  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) ok = 1;
    end
    check("drain", {31'h0, ok}, 1);
    tick();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.s_word_valid = 1'b0;
    bus.s_word_addr = '0;
    bus.s_word_data = '0;
    bus.m_byte_tready = 1'b1;
    #1;
    check("rst_ready", {31'h0, bus.s_word_ready}, 0);
    check("rst_tvalid", {31'h0, bus.m_byte_tvalid}, 0);
    check("rst_tdata", {24'h0, bus.m_byte_tdata}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_count", {16'h0, frame_count}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", {31'h0, bus.s_word_ready}, 1);
    check("idle_tready_no_effect", {16'h0, frame_count}, 0);
    send(2'd1, 32'h12345678, w);
    check("hdr_latency", {31'h0, bus.m_byte_tvalid}, 1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("single_valid", {31'h0, bus.m_byte_tvalid}, 1);
    end
    @(negedge clk);
    check("single_busy_drop", {31'h0, busy}, 0);
    check("single_tvalid_drop", {31'h0, bus.m_byte_tvalid}, 0);
    check("single_count", {16'h0, frame_count}, 1);
    tick();
    send(2'd1, 32'h12345678, w);
    repeat (3) tick();
    bus.m_byte_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_tdata_hold", {24'h0, bus.m_byte_tdata}, 32'h56);
      check("bp_tvalid_hold", {31'h0, bus.m_byte_tvalid}, 1);
    end
    tick();
    bus.m_byte_tready = 1'b1;
    wait_idle();
    check("bp_count", {16'h0, frame_count}, 2);
    send(2'd2, 32'h00000000, w);
    fork
      begin
        for (int i = 0; i < 14; i++) begin
          @(negedge clk);
          check("b2b_valid", {31'h0, bus.m_byte_tvalid}, 1);
        end
        @(negedge clk);
        check("b2b_end", {31'h0, bus.m_byte_tvalid}, 0);
      end
    join_none
    send(2'd3, 32'hFFFFFFFF, w);
    check("b2b_accept_in_chk", w, 6);
    wait_idle();
    check("b2b_count", {16'h0, frame_count}, 4);
    send(2'd1, 32'hDEADBEEF, w);
    tick();
    send(2'd0, 32'h01020304, w);
    check("holdoff_wait", w, 5);
    wait_idle();
    check("holdoff_count", {16'h0, frame_count}, 6);
    send(2'd2, 32'hCAFEBABE, w);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", {31'h0, bus.m_byte_tvalid}, 0);
    check("midrst_busy", {31'h0, busy}, 0);
    check("midrst_count", {16'h0, frame_count}, 0);
    check("midrst_ready", {31'h0, bus.s_word_ready}, 0);
    exp_q.delete();
    pos = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("midrst_ready_after", {31'h0, bus.s_word_ready}, 1);
    send(2'd0, 32'hA5A5A5A5, w);
    wait_idle();
    check("midrst_new_count", {16'h0, frame_count}, 1);
    force dut.frame_count_q = 16'hFFFF;
    #1;
    release dut.frame_count_q;
    @(negedge clk);
    check("wrap_preset", {16'h0, frame_count}, 32'hFFFF);
    tick();
    send(2'd3, 32'h1234ABCD, w);
    wait_idle();
    check("wrap_count", {16'h0, frame_count}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
